// File: rtl/hazard_stall_controller.sv
// Load-use / NPU FIFO / cache hazard detection with stall-cause accounting counters
// and a sticky stall watchdog for the five-stage pipeline.
module hazard_stall_controller #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned NPU_CH   = 1,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic [REG_W-1:0]  iIdRegRs,
  input  logic [REG_W-1:0]  iIdRegRt,
  input  logic              iIdUsesRs,
  input  logic              iIdUsesRt,
  input  logic [REG_W-1:0]  iExRegRt,
  input  logic              iExMemRead,
  input  logic              iExRetCmd,
  input  logic [NPU_CH-1:0] iExNpuCfgOp,
  input  logic [NPU_CH-1:0] iExNpuEnqOp,
  input  logic [NPU_CH-1:0] iExNpuDeqOp,
  input  logic [NPU_CH-1:0] iNpuConfigFull,
  input  logic [NPU_CH-1:0] iNpuInputFull,
  input  logic [NPU_CH-1:0] iNpuOutputEmpty,
  input  logic              iInstrCacheValid,
  input  logic              iInstrCacheReady,
  input  logic              iDataCacheValid,
  input  logic              iDataCacheReady,
  input  logic              iCntClr,
  input  logic              iTimeoutClr,
  output logic              oStall,
  output logic              oBubble,
  output logic [2:0]        oStallCause,
  output logic [CNT_W-1:0]  oDataStallCnt,
  output logic [CNT_W-1:0]  oNpuStallCnt,
  output logic [CNT_W-1:0]  oCacheStallCnt,
  output logic [CNT_W-1:0]  oRunLen,
  output logic              oTimeout
);

  // With LOAD_LAT = 1 a single entry is still declared but never made valid.
  localparam int unsigned     SB_N    = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
  localparam bit              HAS_SB  = (LOAD_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_PRE  = CNT_W'(TIMEOUT - 1);

  logic             ex_load_c;
  logic             rs_hit_c, rt_hit_c;
  logic             data_haz_c, npu_haz_c, cache_haz_c, stall_c, advance_c;

  logic [SB_N-1:0]  sb_vld_q, sb_vld_d;
  logic [REG_W-1:0] sb_reg_q [SB_N];
  logic [REG_W-1:0] sb_reg_d [SB_N];

  logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0] npu_cnt_q, npu_cnt_d;
  logic [CNT_W-1:0] cache_cnt_q, cache_cnt_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic             timeout_q, timeout_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign ex_load_c = iExMemRead & ~iExRetCmd & (iExRegRt != '0);

  // Source match against the EX load and every pending scoreboard entry.
  always_comb begin
    rs_hit_c = ex_load_c && (iIdRegRs == iExRegRt);
    rt_hit_c = ex_load_c && (iIdRegRt == iExRegRt);
    for (int unsigned i = 0; i < SB_N; i++) begin
      if (sb_vld_q[i] && (sb_reg_q[i] == iIdRegRs)) rs_hit_c = 1'b1;
      if (sb_vld_q[i] && (sb_reg_q[i] == iIdRegRt)) rt_hit_c = 1'b1;
    end
    data_haz_c = (iIdUsesRs && rs_hit_c && (iIdRegRs != '0)) ||
                 (iIdUsesRt && rt_hit_c && (iIdRegRt != '0));
  end

  assign npu_haz_c   = |((iExNpuCfgOp & iNpuConfigFull) |
                         (iExNpuEnqOp & iNpuInputFull)  |
                         (iExNpuDeqOp & iNpuOutputEmpty));
  assign cache_haz_c = (iInstrCacheValid & ~iInstrCacheReady) |
                       (iDataCacheValid  & ~iDataCacheReady);
  assign stall_c     = data_haz_c | npu_haz_c | cache_haz_c;
  assign advance_c   = ~(npu_haz_c | cache_haz_c);

  assign oStall      = stall_c;
  assign oBubble     = data_haz_c & ~npu_haz_c & ~cache_haz_c;
  assign oStallCause = {cache_haz_c, npu_haz_c, data_haz_c};

  // Loads age only while the pipe moves; a frozen pipe keeps them in place.
  always_comb begin
    sb_vld_d = sb_vld_q;
    sb_reg_d = sb_reg_q;
    if (advance_c) begin
      sb_vld_d[0] = HAS_SB & ex_load_c;
      sb_reg_d[0] = iExRegRt;
      for (int unsigned i = 1; i < SB_N; i++) begin
        sb_vld_d[i] = sb_vld_q[i-1];
        sb_reg_d[i] = sb_reg_q[i-1];
      end
    end
  end

  always_comb begin
    data_cnt_d  = data_cnt_q;
    npu_cnt_d   = npu_cnt_q;
    cache_cnt_d = cache_cnt_q;
    if (iCntClr) begin
      data_cnt_d  = '0;
      npu_cnt_d   = '0;
      cache_cnt_d = '0;
    end else begin
      if (data_haz_c)  data_cnt_d  = sat_inc(data_cnt_q);
      if (npu_haz_c)   npu_cnt_d   = sat_inc(npu_cnt_q);
      if (cache_haz_c) cache_cnt_d = sat_inc(cache_cnt_q);
    end
    run_d     = stall_c ? sat_inc(run_q) : '0;
    timeout_d = timeout_q;
    if (iTimeoutClr) timeout_d = 1'b0;
    if (stall_c && (run_q == TO_PRE)) timeout_d = 1'b1;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      sb_vld_q <= '0;
      for (int unsigned i = 0; i < SB_N; i++) sb_reg_q[i] <= '0;
      data_cnt_q  <= '0;
      npu_cnt_q   <= '0;
      cache_cnt_q <= '0;
      run_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      sb_vld_q    <= sb_vld_d;
      sb_reg_q    <= sb_reg_d;
      data_cnt_q  <= data_cnt_d;
      npu_cnt_q   <= npu_cnt_d;
      cache_cnt_q <= cache_cnt_d;
      run_q       <= run_d;
      timeout_q   <= timeout_d;
    end
  end

  assign oDataStallCnt  = data_cnt_q;
  assign oNpuStallCnt   = npu_cnt_q;
  assign oCacheStallCnt = cache_cnt_q;
  assign oRunLen        = run_q;
  assign oTimeout       = timeout_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: LOAD_LAT=3 main instance plus a LOAD_LAT=1 instance
// on the same inputs, both checked against a queue-based reference model.
module tb_hazard_stall_controller;
  localparam int unsigned RW  = 5;
  localparam int unsigned LAT = 3;
  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned TO  = 8;
  localparam int          MAXV = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic [RW-1:0] rs, rt_id, ex_rt;
  logic uses_rs, uses_rt, mem_rd, ret;
  logic [NCH-1:0] cfg, enq, deq, cfg_full, in_full, out_empty;
  logic icv, icr, dcv, dcr, cnt_clr, to_clr;

  logic stall, bubble, tmo;
  logic [2:0] cause;
  logic [CW-1:0] dcnt, ncnt, ccnt, run;
  logic stall1, bubble1, tmo1;
  logic [2:0] cause1;
  logic [CW-1:0] dcnt1, ncnt1, ccnt1, run1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: pending load destinations, youngest first (0 = empty slot).
  int m_sb[$];
  int m_d, m_n, m_c, m_run;
  bit m_tmo;

  always #5 clk = ~clk;

  hazard_stall_controller #(.REG_W(RW), .LOAD_LAT(LAT), .NPU_CH(NCH), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .iClk(clk), .iRstN(rst_n), .iIdRegRs(rs), .iIdRegRt(rt_id), .iIdUsesRs(uses_rs),
    .iIdUsesRt(uses_rt), .iExRegRt(ex_rt), .iExMemRead(mem_rd), .iExRetCmd(ret),
    .iExNpuCfgOp(cfg), .iExNpuEnqOp(enq), .iExNpuDeqOp(deq), .iNpuConfigFull(cfg_full),
    .iNpuInputFull(in_full), .iNpuOutputEmpty(out_empty), .iInstrCacheValid(icv),
    .iInstrCacheReady(icr), .iDataCacheValid(dcv), .iDataCacheReady(dcr), .iCntClr(cnt_clr),
    .iTimeoutClr(to_clr), .oStall(stall), .oBubble(bubble), .oStallCause(cause),
    .oDataStallCnt(dcnt), .oNpuStallCnt(ncnt), .oCacheStallCnt(ccnt), .oRunLen(run),
    .oTimeout(tmo));

  hazard_stall_controller #(.REG_W(RW), .LOAD_LAT(1), .NPU_CH(NCH), .CNT_W(CW), .TIMEOUT(TO)) dut1 (
    .iClk(clk), .iRstN(rst_n), .iIdRegRs(rs), .iIdRegRt(rt_id), .iIdUsesRs(uses_rs),
    .iIdUsesRt(uses_rt), .iExRegRt(ex_rt), .iExMemRead(mem_rd), .iExRetCmd(ret),
    .iExNpuCfgOp(cfg), .iExNpuEnqOp(enq), .iExNpuDeqOp(deq), .iNpuConfigFull(cfg_full),
    .iNpuInputFull(in_full), .iNpuOutputEmpty(out_empty), .iInstrCacheValid(icv),
    .iInstrCacheReady(icr), .iDataCacheValid(dcv), .iDataCacheReady(dcr), .iCntClr(cnt_clr),
    .iTimeoutClr(to_clr), .oStall(stall1), .oBubble(bubble1), .oStallCause(cause1),
    .oDataStallCnt(dcnt1), .oNpuStallCnt(ncnt1), .oCacheStallCnt(ccnt1), .oRunLen(run1),
    .oTimeout(tmo1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hit(input int r, input bit use_sb);
    if (r == 0) return 1'b0;
    if (mem_rd && !ret && ex_rt != 0 && r == int'(ex_rt)) return 1'b1;
    if (use_sb) foreach (m_sb[i]) if (m_sb[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_data(input bit use_sb);
    return (uses_rs && m_hit(int'(rs), use_sb)) || (uses_rt && m_hit(int'(rt_id), use_sb));
  endfunction

  function automatic bit m_npu();
    for (int ch = 0; ch < NCH; ch++) begin
      if (cfg[ch] && cfg_full[ch]) return 1'b1;
      if (enq[ch] && in_full[ch]) return 1'b1;
      if (deq[ch] && out_empty[ch]) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int sat(input int v);
    return (v < MAXV) ? v + 1 : v;
  endfunction

  task automatic m_reset();
    m_sb = {};
    repeat (LAT - 1) m_sb.push_back(0);
    m_d = 0; m_n = 0; m_c = 0; m_run = 0; m_tmo = 1'b0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_dcnt"}, 32'(dcnt), 32'(m_d));
    chk({tag, "_ncnt"}, 32'(ncnt), 32'(m_n));
    chk({tag, "_ccnt"}, 32'(ccnt), 32'(m_c));
    chk({tag, "_run"},  32'(run),  32'(m_run));
    chk({tag, "_tmo"},  32'(tmo),  32'(m_tmo));
  endtask

  task automatic idle();
    rs = '0; rt_id = '0; ex_rt = '0; uses_rs = 0; uses_rt = 0; mem_rd = 0; ret = 0;
    cfg = '0; enq = '0; deq = '0; cfg_full = '0; in_full = '0; out_empty = '0;
    icv = 0; icr = 1; dcv = 0; dcr = 1; cnt_clr = 0; to_clr = 0;
  endtask

  // One clock: check combinational outputs, advance model over the edge, check registers.
  task automatic cycle(input string tag);
    bit d, n, c, d1, st;
    #1;
    d = m_data(1'b1); n = m_npu(); c = icv && !icr || dcv && !dcr; d1 = m_data(1'b0);
    st = d | n | c;
    chk({tag, "_stall"},  32'(stall),  32'(st));
    chk({tag, "_bubble"}, 32'(bubble), 32'(d & ~n & ~c));
    chk({tag, "_cause"},  32'(cause),  32'({c, n, d}));
    chk({tag, "_stall1"}, 32'(stall1), 32'(d1 | n | c));
    chk({tag, "_bubble1"}, 32'(bubble1), 32'(d1 & ~n & ~c));
    @(posedge clk);
    if (rst_n) begin
      if (cnt_clr) begin
        m_d = 0; m_n = 0; m_c = 0;
      end else begin
        if (d) m_d = sat(m_d);
        if (n) m_n = sat(m_n);
        if (c) m_c = sat(m_c);
      end
      if (st && m_run == int'(TO) - 1) m_tmo = 1'b1;
      else if (to_clr) m_tmo = 1'b0;
      m_run = st ? sat(m_run) : 0;
      if (!(n | c)) begin
        m_sb.push_front((mem_rd && !ret && ex_rt != 0) ? int'(ex_rt) : 0);
        void'(m_sb.pop_back());
      end
    end
    #1;
    chk_regs(tag);
  endtask

  task automatic load_consume(input int gap, input int cstall, input string tag);
    idle(); repeat (3) cycle("flush");
    mem_rd = 1; ex_rt = 7; cycle({tag, "_ld"});
    idle();
    for (int k = 1; k < gap; k++) begin
      if (k >= 1 && k <= cstall) begin dcv = 1; dcr = 0; end
      else begin dcv = 0; dcr = 1; end
      rs = 5'(k + 1); uses_rs = 1;
      cycle({tag, "_indep"});
    end
    idle(); rs = 7; uses_rs = 1;
    #1 chk({tag, "_window"}, 32'(stall), 32'(gap <= 2 + cstall));
    cycle({tag, "_cons"});
    idle();
  endtask

  initial begin
    idle(); m_reset();
    rst_n = 0;
    #12;
    chk_regs("rst");
    mem_rd = 1; ex_rt = 5; rs = 5; uses_rs = 1;
    cycle("in_rst");
    rst_n = 1;

    // Single-cycle load-use cases
    idle(); mem_rd = 1; ex_rt = 5; rs = 5; uses_rs = 1;
    #1 chk("lu_cause1", 32'(cause1), 32'(3'b001));
    chk("lu_bubble1", 32'(bubble1), 32'd1);
    cycle("lu");
    uses_rs = 0; #1 chk("lu_nouse1", 32'(stall1), 32'd0);
    cycle("lu_nouse");
    uses_rs = 1; ex_rt = 0; #1 chk("lu_r0_1", 32'(stall1), 32'd0);
    cycle("lu_r0");
    ret = 1; ex_rt = 5; cycle("lu_ret");

    // Scoreboard window, plain and stretched by a 4-cycle data-cache stall
    for (int g = 1; g <= 3; g++) load_consume(g, 0, "win");
    load_consume(6, 4, "winst");
    load_consume(7, 4, "winst");

    // Per-channel NPU hazards
    idle(); enq = 4'b0100; in_full = 4'b1011;
    #1 chk("npu_nohit", 32'(stall), 32'd0);
    cycle("npu_a");
    in_full = 4'b0100;
    #1 chk("npu_cause", 32'(cause), 32'(3'b010));
    chk("npu_bubble", 32'(bubble), 32'd0);
    cycle("npu_b");
    idle(); cfg = 4'b0001; cfg_full = 4'b0001; deq = 4'b1000; cycle("npu_c");
    idle(); deq = 4'b1000; out_empty = 4'b1000; cycle("npu_d");

    // Data + cache together, then clear under hazard
    idle(); cycle("pre_clr"); cnt_clr = 1; cycle("clr0");
    idle(); mem_rd = 1; ex_rt = 3; rs = 3; uses_rs = 1; icv = 1; icr = 0;
    repeat (10) cycle("dc");
    chk("dc_dcnt10", 32'(dcnt), 32'd10);
    chk("dc_ccnt10", 32'(ccnt), 32'd10);
    cnt_clr = 1; cycle("dc_clr");
    chk("dc_clr_d", 32'(dcnt), 32'd0);
    chk("dc_clr_c", 32'(ccnt), 32'd0);

    // Watchdog
    idle(); to_clr = 1; cycle("to_clr");
    idle(); dcv = 1; dcr = 0;
    repeat (7) cycle("to_run");
    chk("to_pre", 32'(tmo), 32'd0);
    cycle("to_cross");
    chk("to_set", 32'(tmo), 32'd1);
    idle(); cycle("to_ready");
    chk("to_sticky", 32'(tmo), 32'd1);
    to_clr = 1; cycle("to_clr2");
    chk("to_cleared", 32'(tmo), 32'd0);
    idle(); icv = 1; icr = 0;
    repeat (7) cycle("to_run2");
    to_clr = 1; cycle("to_coinc");
    chk("to_setwins", 32'(tmo), 32'd1);

    // Async reset mid-run with a live scoreboard entry
    idle(); cycle("ar_idle");
    mem_rd = 1; ex_rt = 9; cycle("ar_ld");
    idle(); icv = 1; icr = 0;
    repeat (5) cycle("ar_run");
    chk("ar_run5", 32'(run), 32'd5);
    idle(); rs = 9; uses_rs = 1;
    #1 chk("ar_sb_live", 32'(stall), 32'd1);
    #1 rst_n = 0; m_reset();
    #1 chk_regs("ar");
    chk("ar_sb_gone", 32'(stall), 32'd0);
    @(negedge clk) rst_n = 1;
    cycle("ar_after");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rs = 5'($urandom_range(0, 7)); rt_id = 5'($urandom_range(0, 7));
      ex_rt = 5'($urandom_range(0, 7));
      uses_rs = 1'($urandom); uses_rt = 1'($urandom);
      mem_rd = ($urandom_range(0, 9) < 4); ret = ($urandom_range(0, 9) == 0);
      cfg = 4'($urandom); enq = 4'($urandom); deq = 4'($urandom);
      cfg_full = 4'($urandom & $urandom & $urandom);
      in_full = 4'($urandom & $urandom & $urandom);
      out_empty = 4'($urandom & $urandom & $urandom);
      icv = 1'($urandom); icr = ($urandom_range(0, 9) != 0);
      dcv = 1'($urandom); dcr = ($urandom_range(0, 9) != 0);
      cnt_clr = ($urandom_range(0, 49) == 0); to_clr = ($urandom_range(0, 19) == 0);
      cycle("rnd");
    end

    // Saturation of counters and run length
    idle(); cnt_clr = 1; cycle("sat_clr");
    idle(); icv = 1; icr = 0;
    repeat (300) cycle("sat");
    chk("sat_ccnt", 32'(ccnt), 32'(MAXV));
    chk("sat_run", 32'(run), 32'(MAXV));
    idle(); cycle("sat_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
